cmd_dispatch: RTL and testbench
===============================

CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 72, meaning the FIFO entry width in bits.
REQ-002 SHALL have parameter FENCE_ADDR, default 7'h7F, meaning the register address decoded as a fence, not a write.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: permits fetching new commands.
REQ-006 SHALL have port fifo_rd_en, output, 1 bit: pop strobe to the command async_fifo read side.
REQ-007 SHALL have port fifo_rd_data, input, WIDTH bits: FIFO output, valid the cycle after fifo_rd_en.
REQ-008 SHALL have port fifo_rd_empty, input, 1 bit: FIFO empty flag.
REQ-009 SHALL have port reg_wr_valid, output, 1 bit: a register write is offered.
REQ-010 SHALL have port reg_wr_ready, input, 1 bit: the register file accepts the offered write.
REQ-011 SHALL have port reg_wr_addr, output, 7 bits: register address.
REQ-012 SHALL have port reg_wr_data, output, 64 bits: register data.
REQ-013 SHALL have port pipe_idle, input, 1 bit: the render pipeline is drained.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port cmd_count, output, 16 bits: count of completed commands.

Function
REQ-016 SHALL decode each entry as: [71] reserved and ignored, [70:64] address, [63:0] data.
REQ-017 SHALL implement states IDLE, LOAD, ISSUE and FENCE.
REQ-018 SHALL drive fifo_rd_en combinationally as (state==IDLE) && enable && !fifo_rd_empty, and move IDLE->LOAD on that cycle's edge.
REQ-019 SHALL assert fifo_rd_en for exactly one cycle per command; it is never high outside IDLE.
REQ-020 SHALL in LOAD capture fifo_rd_data into internal address and data registers.
REQ-021 SHALL leave LOAD after exactly one cycle: to FENCE if the address equals FENCE_ADDR, else to ISSUE.
REQ-022 SHALL in ISSUE hold reg_wr_valid=1 with stable reg_wr_addr and reg_wr_data until the cycle reg_wr_ready=1.
REQ-023 SHALL, on the cycle reg_wr_valid and reg_wr_ready are both high, complete the transfer, increment cmd_count and go to IDLE.
REQ-024 SHALL give first reg_wr_valid assertion 2 cycles after the fifo_rd_en cycle; with reg_wr_ready tied high, sustained throughput is one command per 3 cycles.
REQ-025 SHALL in FENCE keep reg_wr_valid=0 and wait for pipe_idle=1, then increment cmd_count and go to IDLE.
REQ-026 SHALL, if pipe_idle is already 1 on the first FENCE cycle, complete the fence in that same cycle.
REQ-027 SHALL, when enable deasserts mid-command, finish the current command normally and fetch nothing further until enable=1.
REQ-028 SHALL never pop while fifo_rd_empty=1; an empty FIFO holds IDLE indefinitely.
REQ-029 SHALL wrap cmd_count from 16'hFFFF to 16'h0000 without saturating.
REQ-030 SHALL ignore reg_wr_ready outside ISSUE.
REQ-031 SHALL keep reg_wr_addr and reg_wr_data registered; they are don't-care while reg_wr_valid=0.

Reset
REQ-032 SHALL, while rst_n=0 at a clk edge, force state=IDLE and cmd_count=0.
REQ-033 SHALL, while rst_n=0 at a clk edge, drive reg_wr_valid=0 and busy=0.
REQ-034 SHALL, while rst_n=0 at a clk edge, clear the address and data registers to 0.
REQ-035 SHALL hold fifo_rd_en=0 during reset.
REQ-036 SHALL, on reset mid-command, discard the latched command, which is lost and not re-fetched.

Verification
REQ-037 Bench SHALL cover: reset release with the FIFO empty -> busy=0, fifo_rd_en never 1, cmd_count=0.
REQ-038 Bench SHALL cover: one entry {addr 7'h10, data 64'h0123_4567_89AB_CDEF}, ready tied high -> valid 2 cycles after the pop, correct addr/data, cmd_count=1.
REQ-039 Bench SHALL cover: ready held low for 5 cycles -> valid, addr and data stable for all 5 cycles, exactly one transfer, no extra pop.
REQ-040 Bench SHALL cover: fence entry (addr 7'h7F) with pipe_idle low for 10 cycles -> no reg_wr_valid, busy=1, no pop; pipe_idle high -> IDLE, cmd_count increments.
REQ-041 Bench SHALL cover: 8 queued writes with enable deasserted after the 3rd pop -> exactly 3 transfers in order, cmd_count=3, 5 entries remaining.
REQ-042 Bench SHALL cover: rst_n pulsed during ISSUE -> next cycle valid=0, cmd_count=0; after release the next FIFO entry is fetched.

Source files
------------

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: pops commands from the FIFO and issues each one as a register write or as a pipeline fence.
// A fence waits for pipe_idle. cmd_count counts both kinds of completed command and wraps.
module cmd_dispatch #(
    parameter int         WIDTH      = 72,
    parameter logic [6:0] FENCE_ADDR = 7'h7F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_rd_empty,
    output logic             reg_wr_valid,
    input  logic             reg_wr_ready,
    output logic [6:0]       reg_wr_addr,
    output logic [63:0]      reg_wr_data,
    input  logic             pipe_idle,
    output logic             busy,
    output logic [15:0]      cmd_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] FENCE = 2'd3;
    logic [1:0]  state;
    logic [6:0]  addr;
    logic [63:0] data;
    logic        done;
    logic        unused_reserved;
    assign unused_reserved = ^fifo_rd_data[WIDTH-1:71];
    // Gating with rst_n keeps the pop strobe low during reset, even though state is still unknown.
    assign fifo_rd_en   = rst_n && state == IDLE && enable && !fifo_rd_empty;
    assign reg_wr_valid = state == ISSUE;
    assign busy         = state != IDLE;
    assign reg_wr_addr  = addr;
    assign reg_wr_data  = data;
    assign done         = (state == ISSUE && reg_wr_ready) || (state == FENCE && pipe_idle);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_count <= 16'd0;
            addr      <= 7'd0;
            data      <= 64'd0;
        end else begin
            state <= state == IDLE ? (fifo_rd_en ? LOAD : IDLE) :
                     state == LOAD ? (fifo_rd_data[70:64] == FENCE_ADDR ? FENCE : ISSUE) :
                     done ? IDLE : state;
            if (state == LOAD) begin
                addr <= fifo_rd_data[70:64];
                data <= fifo_rd_data[63:0];
            end
            if (done) cmd_count <= cmd_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: a transaction-level model and a FIFO stand-in drive cmd_dispatch.
// Directed scenarios with literal expectations come first, then a randomized phase.
module tb_cmd_dispatch;
    logic        clk = 0, rst_n = 0, enable = 0, fifo_rd_empty = 1, reg_wr_ready = 0, pipe_idle = 0;
    logic        fifo_rd_en, reg_wr_valid, busy;
    logic [71:0] fifo_rd_data = '0;
    logic [6:0]  reg_wr_addr;
    logic [63:0] reg_wr_data;
    logic [15:0] cmd_count;

    cmd_dispatch dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .reg_wr_valid(reg_wr_valid), .reg_wr_ready(reg_wr_ready),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .pipe_idle(pipe_idle), .busy(busy), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [71:0] q[$];
    logic [71:0] ref_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [71:0] e);
        q.push_back(e);
        ref_q.push_back(e);
        fifo_rd_empty = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !reg_wr_valid; i++) tick(1);
        check(name, 64'(reg_wr_valid), 64'd1);
    endtask

    // The FIFO stand-in presents a popped entry on the cycle after the pop request.
    logic pop_req = 0;
    always @(posedge clk)
        if (pop_req && q.size() > 0) begin
            fifo_rd_data  <= q.pop_front();
            fifo_rd_empty <= (q.size() == 0);
        end

    // The model tracks one in-flight command and the number of cycles since it was popped.
    logic        m_pend = 0;
    int          m_age = 0;
    logic [71:0] m_cur = '0;
    logic [15:0] m_cnt = '0;
    int          pops = 0, xfers = 0, valid_cycles = 0, cyc = 0, pop_cyc = 0, valid_cyc = 0;
    logic        prev_valid = 0;
    logic [6:0]  last_addr = '0;
    logic [63:0] last_data = '0;

    always @(negedge clk) begin
        logic e_rd, e_valid, fence, done;
        fence   = m_cur[70:64] == 7'h7F;
        e_rd    = rst_n && !m_pend && enable && ref_q.size() != 0;
        e_valid = m_pend && m_age >= 2 && !fence;
        check("rd_en", 64'(fifo_rd_en), 64'(e_rd));
        check("busy", 64'(busy), 64'(m_pend));
        check("valid", 64'(reg_wr_valid), 64'(e_valid));
        check("count", 64'(cmd_count), 64'(m_cnt));
        if (e_valid) begin
            check("addr", 64'(reg_wr_addr), 64'(m_cur[70:64]));
            check("data", reg_wr_data, m_cur[63:0]);
        end
        if (fifo_rd_en) begin
            pops++;
            pop_cyc = cyc;
        end
        if (reg_wr_valid && reg_wr_ready) begin
            xfers++;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
        if (reg_wr_valid) valid_cycles++;
        if (reg_wr_valid && !prev_valid) valid_cyc = cyc;
        prev_valid = reg_wr_valid;
        cyc++;
        pop_req = fifo_rd_en;
        done = m_pend && m_age >= 2 && (fence ? pipe_idle : reg_wr_ready);
        if (!rst_n) begin
            m_pend = 0;
            m_cnt  = '0;
        end else if (e_rd) begin
            m_pend = 1;
            m_age  = 1;
            m_cur  = ref_q.pop_front();
        end else if (done) begin
            m_pend = 0;
            m_cnt  = m_cnt + 16'd1;
        end else if (m_pend) m_age++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, x0, v0, n;
        logic [71:0] ents[8];
        logic [71:0] e;
        tick(3);
        rst_n  = 1;
        enable = 1;
        p0 = pops;
        tick(6);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_count", 64'(cmd_count), 64'd0);
        check("idle_no_pop", 64'(pops - p0), 64'd0);
        check("idle_rd_en", 64'(fifo_rd_en), 64'd0);

        reg_wr_ready = 1;
        x0 = xfers;
        push({1'b0, 7'h10, 64'h0123_4567_89AB_CDEF});
        tick(6);
        check("single_latency", 64'(valid_cyc - pop_cyc), 64'd2);
        check("single_addr", 64'(last_addr), 64'h10);
        check("single_data", last_data, 64'h0123_4567_89AB_CDEF);
        check("single_xfers", 64'(xfers - x0), 64'd1);
        check("single_count", 64'(cmd_count), 64'd1);

        reg_wr_ready = 0;
        x0 = xfers;
        p0 = pops;
        push({1'b1, 7'h22, 64'hDEAD_BEEF_0000_5A5A});
        wait_valid("hold_reach_valid");
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(reg_wr_valid), 64'd1);
            check("hold_addr", 64'(reg_wr_addr), 64'h22);
            check("hold_data", reg_wr_data, 64'hDEAD_BEEF_0000_5A5A);
            tick(1);
        end
        reg_wr_ready = 1;
        tick(3);
        check("hold_xfers", 64'(xfers - x0), 64'd1);
        check("hold_pops", 64'(pops - p0), 64'd1);
        check("hold_count", 64'(cmd_count), 64'd2);

        pipe_idle = 0;
        v0 = valid_cycles;
        p0 = pops;
        push({1'b0, 7'h7F, 64'h1});
        tick(12);
        check("fence_busy", 64'(busy), 64'd1);
        check("fence_no_valid", 64'(valid_cycles - v0), 64'd0);
        check("fence_pops", 64'(pops - p0), 64'd1);
        check("fence_count_wait", 64'(cmd_count), 64'd2);
        pipe_idle = 1;
        tick(2);
        check("fence_done_busy", 64'(busy), 64'd0);
        check("fence_done_count", 64'(cmd_count), 64'd3);

        rst_n = 0;
        tick(1);
        rst_n  = 1;
        enable = 0;
        for (int i = 0; i < 8; i++) begin
            ents[i] = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 126)), $urandom(), $urandom()};
            push(ents[i]);
        end
        x0 = xfers;
        p0 = pops;
        enable = 1;
        for (int i = 0; i < 30 && pops - p0 < 3; i++) tick(1);
        enable = 0;
        tick(10);
        check("enable_pops", 64'(pops - p0), 64'd3);
        check("enable_xfers", 64'(xfers - x0), 64'd3);
        check("enable_count", 64'(cmd_count), 64'd3);
        check("enable_left", 64'(q.size()), 64'd5);
        check("enable_last_addr", 64'(last_addr), 64'(ents[2][70:64]));
        check("enable_last_data", last_data, ents[2][63:0]);

        reg_wr_ready = 0;
        enable = 1;
        wait_valid("rst_reach_issue");
        tick(1);
        rst_n = 0;
        tick(1);
        check("rst_valid", 64'(reg_wr_valid), 64'd0);
        check("rst_count", 64'(cmd_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1;
        reg_wr_ready = 1;
        x0 = xfers;
        for (int i = 0; i < 20 && xfers == x0; i++) tick(1);
        check("rst_next_addr", 64'(last_addr), 64'(ents[4][70:64]));
        check("rst_next_data", last_data, ents[4][63:0]);

        for (int i = 0; i < 600; i++) begin
            enable       = $urandom_range(0, 3) != 0;
            reg_wr_ready = 1'($urandom_range(0, 1));
            pipe_idle    = $urandom_range(0, 2) == 0;
            rst_n        = $urandom_range(0, 99) != 0;
            if ($urandom_range(0, 2) == 0 && q.size() < 16) begin
                e = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom(), $urandom()};
                if ($urandom_range(0, 4) == 0) e[70:64] = 7'h7F;
                push(e);
            end
            tick(1);
        end
        rst_n = 1;
        enable = 1;
        reg_wr_ready = 1;
        pipe_idle = 1;
        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            tick(1);
            n++;
        end
        check("drain_done", 64'(q.size() != 0 || busy), 64'd0);
        tick(2);
        check("final_count", 64'(cmd_count), 64'(m_cnt));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
